// File: rtl/uart_link_matrix.sv
// Purpose : routes N_NODES UART TX lines to RX lines through a glitch-free, idle-gated route table.
// Latency : node_tx_i -> node_rx_o is SYNC_STAGES+1 clocks; a route switch lands one clock after route_cur changes.
// Backpr. : none on the data path; route_we_i is dropped while route_busy_o is high (no queueing).
// Ports   : clk_i/rst_ni (async active-low); node_tx_i/node_rx_o serial lines; route_sel_i/route_we_i
//           program the table; route_busy_o/route_cur_o/link_idle_o report state; stats_clr_i/frame_cnt_o
//           are per-destination start-bit counters.
// Config  : define LINK_STATS_EN to build the frame counters; otherwise frame_cnt_o is tied to zero.
module uart_link_matrix #(
    parameter int N_NODES     = 4,
    parameter int SYNC_STAGES = 2,
    parameter int IDLE_CYCLES = 4340,
    localparam int SELW       = $clog2(N_NODES + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [N_NODES-1:0]       node_tx_i,
    output logic [N_NODES-1:0]       node_rx_o,
    input  logic [N_NODES*SELW-1:0]  route_sel_i,
    input  logic                     route_we_i,
    output logic                     route_busy_o,
    output logic [N_NODES*SELW-1:0]  route_cur_o,
    output logic [N_NODES-1:0]       link_idle_o,
    input  logic                     stats_clr_i,
    output logic [N_NODES*16-1:0]    frame_cnt_o
);

    localparam int CNTW = $clog2(IDLE_CYCLES + 1);
    localparam logic [CNTW-1:0] IDLE_MAX = CNTW'(IDLE_CYCLES);
    // Every SELW-bit select value has a slot; slots >= N_NODES read as a
    // permanently idle, permanently high line, which is what a disconnect means.
    localparam int NEXT = 1 << SELW;

    typedef enum logic {ST_IDLE, ST_PEND} state_t;

    function automatic logic [SELW-1:0] xover(input int d);
        return ((d ^ 1) < N_NODES) ? SELW'(d ^ 1) : SELW'(d);
    endfunction

    logic [N_NODES-1:0] sync_q [SYNC_STAGES];
    logic [CNTW-1:0]    idle_cnt_q [N_NODES];
    logic [SELW-1:0]    route_cur_q [N_NODES];
    logic [SELW-1:0]    pend_q [N_NODES];
    logic [N_NODES-1:0] pend_mask_q, pend_mask_d;
    logic [N_NODES-1:0] apply;
    logic [N_NODES-1:0] rx_q, rx_d;
    logic [NEXT-1:0]    tx_ext, idle_ext;
    logic               accept;
    state_t             state_q, state_d;

    // ---------------- input synchronisers ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '1;
        end else begin
            sync_q[0] <= node_tx_i;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    // ---------------- per-source idle counters ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < N_NODES; s++) idle_cnt_q[s] <= IDLE_MAX;
        end else begin
            for (int s = 0; s < N_NODES; s++) begin
                if (!sync_q[SYNC_STAGES-1][s])
                    idle_cnt_q[s] <= '0;
                else if (idle_cnt_q[s] != IDLE_MAX)
                    idle_cnt_q[s] <= idle_cnt_q[s] + 1'b1;
            end
        end
    end

    always_comb begin
        link_idle_o = '0;
        for (int s = 0; s < N_NODES; s++) link_idle_o[s] = (idle_cnt_q[s] == IDLE_MAX);
    end

    always_comb begin
        tx_ext   = '1;
        idle_ext = '1;
        tx_ext[N_NODES-1:0]   = sync_q[SYNC_STAGES-1];
        idle_ext[N_NODES-1:0] = link_idle_o;
    end

    // ---------------- route update FSM ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        pend_mask_d = pend_mask_q;
        apply       = '0;
        accept      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (route_we_i) begin
                    accept      = 1'b1;
                    pend_mask_d = '1;
                    state_d     = ST_PEND;
                end
            end
            ST_PEND: begin
                // Old and new source must both be quiet, even when they are the same line.
                for (int d = 0; d < N_NODES; d++)
                    apply[d] = pend_mask_q[d] && idle_ext[route_cur_q[d]] && idle_ext[pend_q[d]];
                pend_mask_d = pend_mask_q & ~apply;
                if (pend_mask_d == '0) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_mask_q <= '0;
            for (int d = 0; d < N_NODES; d++) begin
                pend_q[d]      <= '0;
                route_cur_q[d] <= xover(d);
            end
        end else begin
            pend_mask_q <= pend_mask_d;
            for (int d = 0; d < N_NODES; d++) begin
                if (accept)   pend_q[d]      <= route_sel_i[d*SELW +: SELW];
                if (apply[d]) route_cur_q[d] <= pend_q[d];
            end
        end
    end

    assign route_busy_o = (state_q == ST_PEND);

    always_comb begin
        route_cur_o = '0;
        for (int d = 0; d < N_NODES; d++) route_cur_o[d*SELW +: SELW] = route_cur_q[d];
    end

    // ---------------- registered output crossbar ----------------
    always_comb begin
        rx_d = '1;
        for (int d = 0; d < N_NODES; d++) rx_d[d] = tx_ext[route_cur_q[d]];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rx_q <= '1;
        else         rx_q <= rx_d;
    end

    assign node_rx_o = rx_q;

    // ---------------- optional start-bit counters ----------------
`ifdef LINK_STATS_EN
    logic [15:0] frame_cnt_q [N_NODES];

    // A start bit is counted at the edge where node_rx_o falls.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int d = 0; d < N_NODES; d++) frame_cnt_q[d] <= '0;
        end else if (stats_clr_i) begin
            for (int d = 0; d < N_NODES; d++) frame_cnt_q[d] <= '0;
        end else begin
            for (int d = 0; d < N_NODES; d++)
                if (rx_q[d] && !rx_d[d]) frame_cnt_q[d] <= frame_cnt_q[d] + 16'd1;
        end
    end

    always_comb begin
        frame_cnt_o = '0;
        for (int d = 0; d < N_NODES; d++) frame_cnt_o[d*16 +: 16] = frame_cnt_q[d];
    end
`else
    logic unused_stats_clr;
    assign unused_stats_clr = stats_clr_i;
    assign frame_cnt_o      = '0;
`endif

endmodule
